// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_e;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREGS = 32;

endpackage : regfile_pkg

// File: rtl/regfile_rd_port.sv
// One combinational read port: index mux over the flattened register view.
// Same-cycle write bypass is compiled in only when REGFILE_MP_BYPASS_EN is defined.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int NREGS = DEF_NREGS,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic [NREGS*XLEN-1:0] regs_flat,
   input  logic [AW-1:0]         sel,
   input  logic                  busy,
`ifdef REGFILE_MP_BYPASS_EN
   input  logic                  w0_hit,
   input  logic [AW-1:0]         w0_sel,
   input  logic [XLEN-1:0]       w0_data,
   input  logic                  w1_hit,
   input  logic [AW-1:0]         w1_sel,
   input  logic [XLEN-1:0]       w1_data,
`endif
   output logic [XLEN-1:0]       data
);

   always_comb begin
      data = regs_flat[sel*XLEN +: XLEN];
`ifdef REGFILE_MP_BYPASS_EN
      // hit flags already exclude index 0, busy and sweep-start cycles
      if (w1_hit && (w1_sel == sel)) begin
         data = w1_data;
      end else if (w0_hit && (w0_sel == sel)) begin
         data = w0_data;
      end
`endif
      if (busy) begin
         data = '0;
      end
   end

endmodule : regfile_rd_port

// File: rtl/regfile_mp.sv
// Multi-port register file with hardware clear sweep and debug read port.
// Optional same-cycle write-to-read bypass: define REGFILE_MP_BYPASS_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int NREGS = DEF_NREGS,
   parameter int NRD   = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              clr_req,
   output logic                              busy,
   input  logic [NRD*$clog2(NREGS)-1:0]      r_sel,
   output logic [NRD*XLEN-1:0]               r_data,
   input  logic                              w0_en,
   input  logic [$clog2(NREGS)-1:0]          w0_sel,
   input  logic [XLEN-1:0]                   w0_data,
   input  logic                              w1_en,
   input  logic [$clog2(NREGS)-1:0]          w1_sel,
   input  logic [XLEN-1:0]                   w1_data,
   input  logic [$clog2(NREGS)-1:0]          dbg_sel,
   output logic [XLEN-1:0]                   dbg_data
);

   localparam int AW = $clog2(NREGS);

   state_e          state_reg;
   logic [AW-1:0]   clr_ptr_reg;
   logic [XLEN-1:0] mem [NREGS];
   logic [XLEN-1:0] rd_view [NREGS];
   logic [NREGS*XLEN-1:0] regs_flat;
   logic            w0_ok;
   logic            w1_ok;

   assign busy  = (state_reg == CLEAR);
   // a clear request in the same cycle wins over any write
   assign w0_ok = w0_en && (w0_sel != '0) && !busy && !clr_req;
   assign w1_ok = w1_en && (w1_sel != '0) && !busy && !clr_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= CLEAR;
         clr_ptr_reg <= '0;
      end else begin
         case (state_reg)
            CLEAR: begin
               if (clr_ptr_reg == AW'(NREGS - 1)) begin
                  state_reg   <= IDLE;
                  clr_ptr_reg <= '0;
               end else begin
                  clr_ptr_reg <= clr_ptr_reg + AW'(1);
               end
            end
            default: begin
               if (clr_req) begin
                  state_reg   <= CLEAR;
                  clr_ptr_reg <= '0;
               end
            end
         endcase
      end
   end

   // storage has no reset; zeroing only comes from the sweep
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (busy) begin
            mem[clr_ptr_reg] <= '0;
         end else begin
            if (w0_ok) begin
               mem[w0_sel] <= w0_data;
            end
            if (w1_ok) begin
               mem[w1_sel] <= w1_data;
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_view
         if (gi == 0) begin : g_zero
            assign rd_view[gi] = '0;
         end else begin : g_reg
            assign rd_view[gi] = mem[gi];
         end
         assign regs_flat[gi*XLEN +: XLEN] = rd_view[gi];
      end
   endgenerate

   assign dbg_data = busy ? '0 : rd_view[dbg_sel];

   generate
      for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
         regfile_rd_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
         ) u_rd_port (
            .regs_flat (regs_flat),
            .sel       (r_sel[gi*AW +: AW]),
            .busy      (busy),
`ifdef REGFILE_MP_BYPASS_EN
            .w0_hit    (w0_ok),
            .w0_sel    (w0_sel),
            .w0_data   (w0_data),
            .w1_hit    (w1_ok),
            .w1_sel    (w1_sel),
            .w1_data   (w1_data),
`endif
            .data      (r_data[gi*XLEN +: XLEN])
         );
      end
   endgenerate

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default 32x32, two read ports).
`timescale 1ns/1ps
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int NREGS = 32;
   localparam int NRD = 2;
   localparam int AW = 5;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 clr_req;
   logic                 busy;
   logic [NRD*AW-1:0]    r_sel;
   logic [NRD*XLEN-1:0]  r_data;
   logic                 w0_en, w1_en;
   logic [AW-1:0]        w0_sel, w1_sel, dbg_sel;
   logic [XLEN-1:0]      w0_data, w1_data, dbg_data;

   int errors = 0;
   int checks = 0;
   int n;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
      .r_sel(r_sel), .r_data(r_data),
      .w0_en(w0_en), .w0_sel(w0_sel), .w0_data(w0_data),
      .w1_en(w1_en), .w1_sel(w1_sel), .w1_data(w1_data),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-14s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic rd(input logic [AW-1:0] s0, input logic [AW-1:0] s1, input logic [AW-1:0] sd);
      r_sel   = {s1, s0};
      dbg_sel = sd;
      #1;
   endtask

   task automatic idle_writes();
      w0_en = 1'b0; w1_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clr_req = 1'b0; r_sel = '0; dbg_sel = '0;
      w0_en = 1'b0; w0_sel = '0; w0_data = '0;
      w1_en = 1'b0; w1_sel = '0; w1_data = '0;

      // reset and initial sweep
      step(); step();
      rd(5, 0, 5);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_rdata", r_data[31:0], 32'd0);
      rst = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         if (n == 5) chk("sweep_rdata", r_data[31:0], 32'd0);
         step();
         n++;
      end
      chk("sweep_len", n, 32'd32);
      rd(5, 5, 5);
      chk("x5_zero", r_data[31:0], 32'd0);
      chk("x5_dbg_zero", dbg_data, 32'd0);

      // single write, read next cycle
      w0_en = 1'b1; w0_sel = 5; w0_data = 32'hDEADBEEF;
      step(); idle_writes();
      rd(5, 0, 5);
      chk("x5_rd", r_data[31:0], 32'hDEADBEEF);
      chk("x5_dbg", dbg_data, 32'hDEADBEEF);

      // same-index collision: w1 wins
      w0_en = 1'b1; w0_sel = 7; w0_data = 32'h11;
      w1_en = 1'b1; w1_sel = 7; w1_data = 32'h22;
      step(); idle_writes();
      rd(7, 7, 7);
      chk("x7_w1_wins", r_data[63:32], 32'h22);

      // distinct indices in one cycle
      w0_en = 1'b1; w0_sel = 3; w0_data = 32'h1;
      w1_en = 1'b1; w1_sel = 4; w1_data = 32'h2;
      step(); idle_writes();
      rd(3, 4, 3);
      chk("x3_dual", r_data[31:0], 32'h1);
      chk("x4_dual", r_data[63:32], 32'h2);

      // x0 write ignored, also no bypass on x0
      w1_en = 1'b1; w1_sel = 0; w1_data = 32'hFFFF;
      rd(0, 0, 0);
      chk("x0_same_cyc", r_data[31:0], 32'd0);
      step(); idle_writes();
      rd(0, 0, 0);
      chk("x0_rd", r_data[31:0], 32'd0);
      chk("x0_dbg", dbg_data, 32'd0);

      // same-cycle read of a write target
      w0_en = 1'b1; w0_sel = 9; w0_data = 32'hABCD;
      rd(0, 9, 9);
`ifdef REGFILE_MP_BYPASS_EN
      chk("x9_same_cyc", r_data[63:32], 32'hABCD);
`else
      chk("x9_same_cyc", r_data[63:32], 32'd0);
`endif
      chk("x9_dbg_nobyp", dbg_data, 32'd0);
      step(); idle_writes();
      rd(0, 9, 9);
      chk("x9_rd", r_data[63:32], 32'hABCD);

      // w1 priority on a same-cycle read
      w0_en = 1'b1; w0_sel = 10; w0_data = 32'h55;
      w1_en = 1'b1; w1_sel = 10; w1_data = 32'h66;
      rd(10, 0, 10);
`ifdef REGFILE_MP_BYPASS_EN
      chk("x10_byp_w1", r_data[31:0], 32'h66);
`else
      chk("x10_byp_w1", r_data[31:0], 32'd0);
`endif
      step(); idle_writes();

      // clear request mid-traffic; write on that cycle dropped
      clr_req = 1'b1;
      w0_en = 1'b1; w0_sel = 12; w0_data = 32'h77;
      step();
      clr_req = 1'b0;
      chk("clr_busy", {31'd0, busy}, 32'd1);
      n = 0;
      while (busy && n < 100) begin
         w0_en = 1'b1; w0_sel = 13; w0_data = 32'h99;
         clr_req = (n == 10);
         rd(13, 5, 5);
         if (n == 20) begin
            chk("clr_rdata", r_data[31:0], 32'd0);
            chk("clr_dbg", dbg_data, 32'd0);
         end
         step();
         n++;
      end
      clr_req = 1'b0; idle_writes();
      chk("clr_len", n, 32'd32);
      rd(13, 5, 13);
      chk("x13_dropped", r_data[31:0], 32'd0);
      chk("x5_cleared", r_data[63:32], 32'd0);

      // reset in the middle of a sweep restarts it
      w0_en = 1'b1; w0_sel = 31; w0_data = 32'hFFFFFFFF;
      step(); idle_writes();
      rd(31, 0, 31);
      chk("x31_rd", r_data[31:0], 32'hFFFFFFFF);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (10) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      chk("rst_mid_len", n, 32'd32);
      for (int i = 0; i < NREGS; i++) begin
         rd(AW'(i), AW'(NREGS - 1 - i), AW'(i));
         chk($sformatf("final_x%0d", i), r_data[31:0] | r_data[63:32] | dbg_data, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count; power of two, >= 2.
REQ-003 SHALL have parameter NRD, default 2, meaning number of combinational read ports.
REQ-004 SHALL have derived localparam AW = clog2(NREGS), the index width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 clr_req  in  1  request a full clear sweep while idle.
REQ-008 busy  out  1  clear sweep in progress.
REQ-009 r_sel  in  NRD*AW  read indices, port k at bits [k*AW +: AW].
REQ-010 r_data  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN].
REQ-011 w0_en / w0_sel / w0_data  in  1 / AW / XLEN  write port 0.
REQ-012 w1_en / w1_sel / w1_data  in  1 / AW / XLEN  write port 1; higher priority than port 0.
REQ-013 dbg_sel  in  AW; dbg_data  out  XLEN  debug read port, never bypassed.

Function
REQ-014 SHALL implement a 2-state FSM: CLEAR and IDLE.
REQ-015 In CLEAR, each cycle SHALL zero reg[clr_ptr] and increment clr_ptr.
REQ-016 When clr_ptr == NREGS-1 in CLEAR, the next state SHALL be IDLE and clr_ptr SHALL wrap to 0.
REQ-017 IDLE with clr_req=1 SHALL go to CLEAR on the next edge, with clr_ptr=0.
REQ-018 busy SHALL be 1 exactly while in CLEAR; a sweep lasts NREGS cycles.
REQ-019 clr_req asserted while in CLEAR SHALL be ignored; it does not restart or extend the sweep.
REQ-020 While busy, all writes SHALL be dropped, and r_data and dbg_data SHALL read 0.
REQ-021 In IDLE, a write with wN_en=1 and wN_sel != 0 SHALL update reg[wN_sel] on the edge.
REQ-022 Register 0 SHALL always read 0 and SHALL never be written.
REQ-023 Both write ports targeting the same index in one cycle SHALL store w1_data.
REQ-024 Both write ports targeting distinct indices SHALL both be stored in the same cycle.
REQ-025 Reads SHALL be combinational from r_sel, with zero-cycle latency.
REQ-026 In IDLE with clr_req=1 and a valid write in the same cycle, the write SHALL be dropped; the sweep starts.

Reset
REQ-027 rst=1 SHALL force state CLEAR, clr_ptr=0 and busy=1 on that edge, aborting any sweep in progress.
REQ-028 After rst is released, busy SHALL stay 1 for NREGS cycles; outputs SHALL read 0 throughout.
REQ-029 Storage contents are not reset directly; zeroing happens only through the sweep.

Configuration
REQ-030 Macro REGFILE_MP_BYPASS_EN defined: in IDLE, a read whose index matches a same-cycle valid write SHALL return that write's data, with w1 taking priority over w0.
REQ-031 Macro REGFILE_MP_BYPASS_EN undefined: reads SHALL return pre-edge contents, with no bypass logic.
REQ-032 Bypass SHALL never apply to index 0, to dbg_data, or while busy.

Structure
REQ-033 A shared package regfile_pkg SHALL hold the FSM state enum (CLEAR, IDLE) and the default XLEN/NREGS constants.
REQ-034 One sub-module, regfile_rd_port, SHALL implement a single read mux plus optional bypass, instantiated NRD times via generate.

Verification
REQ-035 Release rst -> busy=1 for 32 cycles, then 0; x5 reads 0.
REQ-036 After clear: w0 writes x5=0xDEADBEEF -> next cycle r_sel port0=5 gives 0xDEADBEEF; dbg_sel=5 gives same.
REQ-037 w0 and w1 both target x7, with 0x11 and 0x22 -> x7 reads 0x22; w0 x3=0x1, w1 x4=0x2 -> both stored.
REQ-038 w1 writes x0=0xFFFF -> x0 reads 0; with bypass, a same-cycle read of x0 also gives 0.
REQ-039 With bypass: w0 x9=0xABCD while r_sel=9 -> r_data=0xABCD in that cycle; without macro -> old value.
REQ-040 clr_req=1 in IDLE mid-traffic -> busy for 32 cycles, writes dropped; rst pulsed mid-sweep -> sweep restarts at ptr 0; afterwards all registers read 0.
